// File: rtl/inj_port_arbiter_if.sv
// Injector/router handshake bundle for the injection-port arbiter.
// The slave modport is the arbiter side; the master modport is the injector/router side.
interface inj_port_arbiter_if #(
    parameter int PACKETWIDTH = 56
);
    logic [3:0]               ReqIn;
    logic [4*PACKETWIDTH-1:0] PacketIn;
    logic [3:0]               GntUp;
    logic                     DnStrFull;
    logic                     GntDnStr;
    logic                     ReqDnStr;
    logic [PACKETWIDTH-1:0]   PacketOut;
    logic [1:0]               Owner;
    logic                     Busy;
    logic [15:0]              PktCnt;
    logic [7:0]               TimeoutCnt;

    modport master (
        output ReqIn, PacketIn, DnStrFull, GntDnStr,
        input  GntUp, ReqDnStr, PacketOut, Owner, Busy, PktCnt, TimeoutCnt
    );

    modport slave (
        input  ReqIn, PacketIn, DnStrFull, GntDnStr,
        output GntUp, ReqDnStr, PacketOut, Owner, Busy, PktCnt, TimeoutCnt
    );
endinterface

// File: rtl/inj_port_arbiter.sv
// Round-robin arbiter funnelling four injectors into one router local port,
// with a bounded wait for the router grant and forwarded/abandoned counters.
module inj_port_arbiter #(
    parameter int PACKETWIDTH = 56,
    parameter int TIMEOUT     = 1000
) (
    input logic               clk,
    input logic               reset,
    inj_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT_DN, RELEASE} state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    state_t                 state;
    logic [1:0]             ptr;
    logic [15:0]            wait_cnt;
    logic [1:0]             sel;
    logic                   sel_vld;
    logic [PACKETWIDTH-1:0] sel_pkt;

    // Walk from the farthest offset back to ptr so the nearest requester wins.
    always_comb begin
        sel     = '0;
        sel_vld = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            if (bus.ReqIn[ptr + 2'(k)]) begin
                sel     = ptr + 2'(k);
                sel_vld = 1'b1;
            end
        end
        sel_pkt = bus.PacketIn[int'(sel)*PACKETWIDTH +: PACKETWIDTH];
    end

    assign bus.Busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            ptr            <= '0;
            wait_cnt       <= '0;
            bus.ReqDnStr   <= 1'b0;
            bus.GntUp      <= '0;
            bus.PacketOut  <= '0;
            bus.Owner      <= '0;
            bus.PktCnt     <= '0;
            bus.TimeoutCnt <= '0;
        end else begin
            bus.GntUp <= '0;
            case (state)
                IDLE: begin
                    if (sel_vld && !bus.DnStrFull) begin
                        bus.Owner     <= sel;
                        bus.PacketOut <= sel_pkt;
                        bus.ReqDnStr  <= 1'b1;
                        wait_cnt      <= '0;
                        state         <= WAIT_DN;
                    end
                end
                WAIT_DN: begin
                    // A grant arriving in the timeout cycle still wins.
                    if (bus.GntDnStr) begin
                        bus.ReqDnStr         <= 1'b0;
                        bus.GntUp[bus.Owner] <= 1'b1;
                        bus.PktCnt           <= bus.PktCnt + 16'd1;
                        ptr                  <= bus.Owner + 2'd1;
                        state                <= RELEASE;
                    end else if (wait_cnt == TO_LAST) begin
                        bus.ReqDnStr <= 1'b0;
                        if (bus.TimeoutCnt != 8'hFF)
                            bus.TimeoutCnt <= bus.TimeoutCnt + 8'd1;
                        ptr          <= bus.Owner + 2'd1;
                        state        <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                RELEASE: begin
                    if (!bus.ReqIn[bus.Owner])
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/inj_port_arbiter.md
INJ_PORT_ARBITER -- requirements
Module: inj_port_arbiter

Interface
REQ-001 Parameter PACKETWIDTH, default 56, packet bus width in bits.
REQ-002 Parameter TIMEOUT, default 1000, maximum cycles spent in WAIT_DN before the request is abandoned; legal range 1..65535.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-low.
REQ-005 ReqIn  input  4  per-injector request; bit i belongs to injector i.
REQ-006 PacketIn  input  4*PACKETWIDTH  injector packets; injector i drives bits [i*PACKETWIDTH +: PACKETWIDTH].
REQ-007 GntUp  output  4  per-injector grant, one-cycle pulse.
REQ-008 DnStrFull  input  1  router local-port FIFO full.
REQ-009 GntDnStr  input  1  grant from the router local port.
REQ-010 ReqDnStr  output  1  request to the router local port.
REQ-011 PacketOut  output  PACKETWIDTH  latched packet of the current owner.
REQ-012 Owner  output  2  index of the last selected injector.
REQ-013 Busy  output  1  high whenever the state is not IDLE.
REQ-014 PktCnt  output  16  count of packets forwarded; wraps at 65535 -> 0.
REQ-015 TimeoutCnt  output  8  count of abandoned requests; saturates at 255.

Function
REQ-016 The block SHALL implement states IDLE, WAIT_DN and RELEASE, plus an internal round-robin pointer Ptr[1:0].
REQ-017 In IDLE, with ReqIn!=0 and DnStrFull=0, the block SHALL select the first set ReqIn bit, searching Ptr, Ptr+1, ... mod 4.
REQ-018 On that selection it SHALL latch Owner and PacketOut, set ReqDnStr=1 on the same edge, clear the wait counter, and go to WAIT_DN.
REQ-019 In IDLE with DnStrFull=1 the block SHALL make no selection and SHALL keep ReqDnStr=0.
REQ-020 In WAIT_DN, PacketOut and Owner SHALL hold stable regardless of ReqIn or PacketIn changes.
REQ-021 In WAIT_DN with GntDnStr=1, on the same edge the block SHALL:
  - set ReqDnStr=0;
  - pulse GntUp[Owner]=1 for exactly one cycle;
  - increment PktCnt;
  - set Ptr=Owner+1 mod 4;
  - go to RELEASE.
REQ-022 In WAIT_DN with GntDnStr=0, the wait counter SHALL increment each cycle.
REQ-023 When the wait counter reaches TIMEOUT-1 with GntDnStr=0, the block SHALL:
  - set ReqDnStr=0;
  - increment TimeoutCnt (saturating);
  - set Ptr=Owner+1 mod 4;
  - issue no GntUp;
  - go to IDLE.
REQ-024 If GntDnStr=1 in the timeout cycle, the grant SHALL take priority over the timeout.
REQ-025 In RELEASE the block SHALL return to IDLE in the first cycle in which ReqIn[Owner]=0, and SHALL make no new selection in that cycle.
REQ-026 GntUp SHALL be one-hot or zero at all times.
REQ-027 GntDnStr received outside WAIT_DN SHALL be ignored.
REQ-028 Requests from non-owners SHALL be held pending without any effect.
REQ-029 Minimum spacing between two ReqDnStr assertions SHALL be 3 cycles (grant, release, select).
REQ-030 Each requester with continuously asserted ReqIn SHALL be served within 4 grants.

Reset
REQ-031 On reset=0, asynchronously and independent of clk, the block SHALL set:
  - state=IDLE, Ptr=0;
  - ReqDnStr=0, GntUp=0;
  - PacketOut=0, Owner=0;
  - PktCnt=0, TimeoutCnt=0, wait counter=0.
REQ-032 Reset asserted mid-WAIT_DN SHALL drop ReqDnStr immediately, and no GntUp SHALL follow after reset release.

Verification
REQ-033 Single requester: ReqIn=0001, DnStrFull=0, GntDnStr two cycles after ReqDnStr rises -> PacketOut=PacketIn[0], GntUp=0001 for one cycle, PktCnt=1, Ptr=1.
REQ-034 Fairness: ReqIn=1111 held, each injector drops its bit one cycle after its GntUp and re-raises it after 2 cycles, router grants immediately -> grant order 0,1,2,3,0; Owner sequence matches.
REQ-035 Backpressure: DnStrFull=1 with ReqIn=0100 for 10 cycles -> ReqDnStr=0, Busy=0 throughout; DnStrFull drops -> ReqDnStr=1 on the next edge, Owner=2.
REQ-036 Timeout: TIMEOUT=8, ReqIn=0010, GntDnStr=0 -> ReqDnStr falls after 8 cycles in WAIT_DN, TimeoutCnt=1, GntUp never set, Ptr=2.
REQ-037 Simultaneous grant and timeout: GntDnStr=1 exactly at count TIMEOUT-1 -> GntUp pulses, PktCnt increments, TimeoutCnt unchanged.
REQ-038 Reset mid-operation: reset=0 while in WAIT_DN -> ReqDnStr=0 and PacketOut=0 within the same cycle, PktCnt=0; after release, ReqIn=1000 -> ReqDnStr=1 with Owner=3.
